// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator core: opcodes, FSM states,
// default operand width and the iteration count of the MUL/DIV datapath.
package calc_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int ITER_COUNT     = 32;
   localparam int CNT_W          = $clog2(ITER_COUNT);

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_MUL = 3'd5,
      OP_DIV = 3'd6,
      OP_RSV = 3'd7
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic is_iter_op(input opcode_e op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/calc_if.sv
// Register-side bundle between the AXI4-Lite slave and the calculator core:
// operands/opcode/start from the slave, result and status back to it.
interface calc_if #(
   parameter int DATA_WIDTH = calc_pkg::DEF_DATA_WIDTH
);
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   logic [2:0]            opcode;
   logic                  start;
   logic [DATA_WIDTH-1:0] result;
   logic                  busy;
   logic                  done;
   logic                  carry;
   logic                  err;

   modport master (
      output op_a, op_b, opcode, start,
      input  result, busy, done, carry, err
   );

   modport slave (
      input  op_a, op_b, opcode, start,
      output result, busy, done, carry, err
   );
endinterface

// File: rtl/calc_iter.sv
// Iterative MUL/DIV datapath: one shift-add (MUL) or restoring-division (DIV)
// step per cycle; res_d is the value the accumulator holds after this step.
module calc_iter
   import calc_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  step,
   input  logic                  is_div,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   output logic [DATA_WIDTH-1:0] res_d
);

   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH:0]   rem_sh;
   logic [DATA_WIDTH:0]   rem_diff;
   logic                  q_bit;

   // MUL: a_q is the shifting multiplicand, b_q the shifting multiplier, acc_q the product.
   // DIV: a_q shifts the dividend out and the quotient in, b_q is the divisor, acc_q the remainder.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      rem_sh   = {acc_q, a_q[DATA_WIDTH-1]};
      rem_diff = rem_sh - {1'b0, b_q};
      q_bit    = ~rem_diff[DATA_WIDTH];
      if (load) begin
         a_d   = a_in;
         b_d   = b_in;
         acc_d = '0;
      end else if (step) begin
         if (is_div) begin
            acc_d = q_bit ? rem_diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
            a_d   = {a_q[DATA_WIDTH-2:0], q_bit};
         end else begin
            acc_d = acc_q + (b_q[0] ? a_q : '0);
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
         end
      end
      res_d = is_div ? a_d : acc_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/calc_core.sv
// Calculator core: single-cycle ALU ops plus 32-step MUL/DIV, sequenced by an
// IDLE/EXEC/DONE FSM with registered result and status outputs.
module calc_core
   import calc_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic  S_AXI_ACLK,
   input  logic  S_AXI_ARESETN,
   calc_if.slave bus
);

   state_e                state_q;
   opcode_e               op_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  carry_q;
   logic                  err_q;
   logic                  div_zero_q;

   opcode_e               opc_in;
   logic [DATA_WIDTH:0]   alu_sum;
   logic [DATA_WIDTH:0]   alu_diff;
   logic [DATA_WIDTH-1:0] alu_res_d;
   logic                  alu_carry_d;
   logic                  alu_err_d;
   logic [DATA_WIDTH-1:0] iter_res_d;
   logic                  accept;

   assign opc_in = opcode_e'(bus.opcode);
   assign accept = (state_q == ST_IDLE) && bus.start;

   always_comb begin
      alu_sum     = {1'b0, bus.op_a} + {1'b0, bus.op_b};
      alu_diff    = {1'b0, bus.op_a} - {1'b0, bus.op_b};
      alu_res_d   = '0;
      alu_carry_d = carry_q;
      alu_err_d   = 1'b0;
      case (opc_in)
         OP_ADD: begin
            alu_res_d   = alu_sum[DATA_WIDTH-1:0];
            alu_carry_d = alu_sum[DATA_WIDTH];
         end
         OP_SUB: begin
            alu_res_d   = alu_diff[DATA_WIDTH-1:0];
            alu_carry_d = alu_diff[DATA_WIDTH];
         end
         OP_AND:  alu_res_d = bus.op_a & bus.op_b;
         OP_OR:   alu_res_d = bus.op_a | bus.op_b;
         OP_XOR:  alu_res_d = bus.op_a ^ bus.op_b;
         OP_RSV:  alu_err_d = 1'b1;
         default: alu_res_d = '0;
      endcase
   end

   calc_iter #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_iter (
      .clk    (S_AXI_ACLK),
      .rst_n  (S_AXI_ARESETN),
      .load   (accept),
      .step   (state_q == ST_EXEC),
      .is_div (op_q == OP_DIV),
      .a_in   (bus.op_a),
      .b_in   (bus.op_b),
      .res_d  (iter_res_d)
   );

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_ADD;
         cnt_q      <= '0;
         result_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         carry_q    <= 1'b0;
         err_q      <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  op_q       <= opc_in;
                  cnt_q      <= '0;
                  busy_q     <= 1'b1;
                  err_q      <= alu_err_d;
                  div_zero_q <= (bus.op_b == '0);
                  if (is_iter_op(opc_in)) begin
                     state_q <= ST_EXEC;
                  end else begin
                     state_q  <= ST_DONE;
                     result_q <= alu_res_d;
                     carry_q  <= alu_carry_d;
                     done_q   <= 1'b1;
                  end
               end
            end
            ST_EXEC: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  // Divide-by-zero still runs the full sequence; the quotient is forced to all ones.
                  if (op_q == OP_DIV && div_zero_q) begin
                     result_q <= '1;
                     err_q    <= 1'b1;
                  end else begin
                     result_q <= iter_res_d;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.result = result_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.carry  = carry_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core: directed scenarios plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_calc_core;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic carry_m;

   calc_if #(.DATA_WIDTH(32)) bus ();

   calc_core #(.DATA_WIDTH(32)) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .bus           (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: what each opcode should produce, from plain arithmetic.
   function automatic void model(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                                 input logic c_in, output logic [31:0] r, output logic c_out,
                                 output logic e);
      logic [63:0] wide;
      r     = 32'd0;
      c_out = c_in;
      e     = 1'b0;
      case (opc)
         3'd0: begin
            wide  = 64'(a) + 64'(b);
            r     = wide[31:0];
            c_out = (wide > 64'hFFFF_FFFF);
         end
         3'd1: begin
            r     = a - b;
            c_out = (a < b);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin
            wide = 64'(a) * 64'(b);
            r    = wide[31:0];
         end
         3'd6: begin
            if (b == 32'd0) begin
               r = 32'hFFFF_FFFF;
               e = 1'b1;
            end else begin
               r = a / b;
            end
         end
         default: e = 1'b1;
      endcase
   endfunction

   // Pulses start for one cycle from a negedge; returns cycles until done (99 on timeout).
   task automatic run_op(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
      bus.op_a   = a;
      bus.op_b   = b;
      bus.opcode = opc;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.done) lat = 99;
   endtask

   task automatic test_reset();
      logic [35:0] obs;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.op_a   = '0;
      bus.op_b   = '0;
      bus.opcode = '0;
      carry_m    = 1'b0;
      repeat (3) @(negedge clk);
      obs = {bus.result, bus.busy, bus.done, bus.carry, bus.err};
      checks++;
      if (obs !== 36'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h expected 0", obs);
      end
      rst_n = 1'b1;
      @(negedge clk);
      obs = {bus.result, bus.busy, bus.done, bus.carry, bus.err};
      checks++;
      if (obs !== 36'd0) begin
         errors++;
         $display("FAIL post_reset_idle got %h expected 0", obs);
      end
      $display("reset: outputs %h", obs);
   endtask

   task automatic test_add();
      int lat;
      run_op(3'd0, 32'hFFFF_FFFF, 32'd1, lat);
      carry_m = 1'b1;
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d expected 1", lat); end
      checks++;
      if (bus.result !== 32'd0) begin errors++; $display("FAIL add_result got %h expected 0", bus.result); end
      checks++;
      if (bus.carry !== 1'b1) begin errors++; $display("FAIL add_carry got %b expected 1", bus.carry); end
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL add_busy_done got %b expected 1", bus.busy); end
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         errors++;
         $display("FAIL add_idle got busy/done %b expected 00", {bus.busy, bus.done});
      end
      $display("add: FFFFFFFF+1 result %h carry %b lat %0d", bus.result, bus.carry, lat);
   endtask

   task automatic test_alu_random();
      logic [2:0]  opc;
      logic [31:0] a, b, r_m;
      logic        c_m, e_m;
      int          lat;
      for (int i = 0; i < 24; i++) begin
         opc = 3'($urandom_range(0, 5));
         if (opc == 3'd5) opc = 3'd7;
         a = (i % 6 == 0) ? 32'hFFFF_FFFF : $urandom;
         b = (i % 5 == 0) ? 32'd0 : $urandom;
         model(opc, a, b, carry_m, r_m, c_m, e_m);
         run_op(opc, a, b, lat);
         carry_m = c_m;
         checks++;
         if ({lat == 1, bus.result, bus.carry, bus.err} !== {1'b1, r_m, c_m, e_m}) begin
            errors++;
            $display("FAIL alu_rand op %0d a %h b %h got res %h c %b e %b lat %0d expected res %h c %b e %b lat 1",
                     opc, a, b, bus.result, bus.carry, bus.err, lat, r_m, c_m, e_m);
         end
         $display("alu: op %0d a %h b %h -> %h c %b e %b", opc, a, b, bus.result, bus.carry, bus.err);
         @(negedge clk);
      end
   endtask

   task automatic test_mul();
      int pulses;
      int bad_busy;
      int done_at;
      bus.op_a   = 32'd7;
      bus.op_b   = 32'd6;
      bus.opcode = 3'd5;
      bus.start  = 1'b1;
      pulses   = 0;
      bad_busy = 0;
      done_at  = 0;
      for (int cyc = 1; cyc <= 34; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done) begin pulses++; done_at = cyc; end
         if (bus.busy !== (cyc <= 33)) bad_busy++;
      end
      checks++;
      if (bus.result !== 32'd42) begin errors++; $display("FAIL mul_result got %0d expected 42", bus.result); end
      checks++;
      if (pulses !== 1 || done_at !== 33) begin
         errors++;
         $display("FAIL mul_done got %0d pulses at %0d expected 1 at 33", pulses, done_at);
      end
      checks++;
      if (bad_busy !== 0) begin errors++; $display("FAIL mul_busy got %0d bad cycles expected 0", bad_busy); end
      $display("mul: 7*6 -> %0d done at %0d", bus.result, done_at);
   endtask

   task automatic test_div();
      int lat;
      run_op(3'd6, 32'd100, 32'd7, lat);
      checks++;
      if ({bus.result, bus.err, lat == 33} !== {32'd14, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL div_100_7 got res %0d err %b lat %0d expected 14 0 33", bus.result, bus.err, lat);
      end
      $display("div: 100/7 -> %0d err %b lat %0d", bus.result, bus.err, lat);
      @(negedge clk);
      run_op(3'd6, 32'd100, 32'd0, lat);
      checks++;
      if ({bus.result, bus.err, lat == 33} !== {32'hFFFF_FFFF, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL div_by_zero got res %h err %b lat %0d expected FFFFFFFF 1 33", bus.result, bus.err, lat);
      end
      $display("div: 100/0 -> %h err %b lat %0d", bus.result, bus.err, lat);
      @(negedge clk);
   endtask

   task automatic test_iter_random();
      logic [2:0]  opc;
      logic [31:0] a, b, r_m;
      logic        c_m, e_m;
      int          lat;
      for (int i = 0; i < 10; i++) begin
         opc = (i % 2 == 0) ? 3'd5 : 3'd6;
         a = $urandom;
         case (i % 4)
            0: b = $urandom;
            1: b = 32'($urandom_range(1, 255));
            2: b = 32'($urandom_range(0, 65535));
            default: b = (i == 7) ? 32'd0 : $urandom;
         endcase
         model(opc, a, b, carry_m, r_m, c_m, e_m);
         run_op(opc, a, b, lat);
         carry_m = c_m;
         checks++;
         if ({lat == 33, bus.result, bus.carry, bus.err} !== {1'b1, r_m, c_m, e_m}) begin
            errors++;
            $display("FAIL iter_rand op %0d a %h b %h got res %h c %b e %b lat %0d expected res %h c %b e %b lat 33",
                     opc, a, b, bus.result, bus.carry, bus.err, lat, r_m, c_m, e_m);
         end
         $display("iter: op %0d a %h b %h -> %h e %b lat %0d", opc, a, b, bus.result, bus.err, lat);
         @(negedge clk);
      end
   endtask

   task automatic test_ignore_start();
      int done_at;
      bus.op_a   = 32'd3;
      bus.op_b   = 32'd5;
      bus.opcode = 3'd5;
      bus.start  = 1'b1;
      done_at    = 0;
      for (int cyc = 1; cyc <= 40 && done_at == 0; cyc++) begin
         @(negedge clk);
         bus.start = (cyc == 10);
         if (cyc == 10) begin
            bus.op_a   = 32'd9;
            bus.op_b   = 32'd0;
            bus.opcode = 3'd6;
         end
         if (bus.done) done_at = cyc;
      end
      checks++;
      if ({bus.result, bus.err} !== {32'd15, 1'b0} || done_at !== 33) begin
         errors++;
         $display("FAIL ignore_start got res %0d err %b done at %0d expected 15 0 at 33", bus.result, bus.err, done_at);
      end
      $display("ignore: 3*5 with re-pulse -> %0d done at %0d", bus.result, done_at);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.result} !== {2'b00, 32'd15}) begin
         errors++;
         $display("FAIL ignore_no_restart got busy %b done %b res %0d expected 0 0 15", bus.busy, bus.done, bus.result);
      end
   endtask

   task automatic test_reset_mid();
      logic [35:0] obs;
      int          lat;
      run_op(3'd0, 32'h8000_0000, 32'h8000_0000, lat);
      @(negedge clk);
      bus.op_a   = 32'd1000;
      bus.op_b   = 32'd3;
      bus.opcode = 3'd6;
      bus.start  = 1'b1;
      for (int cyc = 1; cyc < 15; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      obs = {bus.result, bus.busy, bus.done, bus.carry, bus.err};
      carry_m = 1'b0;
      checks++;
      if (obs !== 36'd0) begin errors++; $display("FAIL reset_mid_div got %h expected 0", obs); end
      $display("reset_mid: outputs %h", obs);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(3'd1, 32'd5, 32'd3, lat);
      checks++;
      if ({bus.result, bus.carry, lat == 1} !== {32'd2, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL sub_after_reset got res %0d carry %b lat %0d expected 2 0 1", bus.result, bus.carry, lat);
      end
      $display("sub: 5-3 -> %0d carry %b", bus.result, bus.carry);
      @(negedge clk);
   endtask

   task automatic test_reserved();
      int lat;
      run_op(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, lat);
      checks++;
      if ({bus.result, bus.err, lat == 1} !== {32'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL reserved_op got res %h err %b lat %0d expected 0 1 1", bus.result, bus.err, lat);
      end
      $display("rsv: -> %h err %b lat %0d", bus.result, bus.err, lat);
      @(negedge clk);
      run_op(3'd2, 32'h0000_F0F0, 32'h0000_FF00, lat);
      checks++;
      if ({bus.result, bus.err} !== {32'h0000_F000, 1'b0}) begin
         errors++;
         $display("FAIL and_after_rsv got res %h err %b expected 0000F000 0", bus.result, bus.err);
      end
      $display("and: F0F0&FF00 -> %h err %b", bus.result, bus.err);
   endtask

   task automatic test_back_to_back();
      int lat;
      // Called while the previous op is in DONE: the next negedge is the first IDLE cycle.
      @(negedge clk);
      run_op(3'd4, 32'hAAAA_5555, 32'hFFFF_0000, lat);
      checks++;
      if ({bus.result, lat == 1} !== {32'h5555_5555, 1'b1}) begin
         errors++;
         $display("FAIL back_to_back_xor got res %h lat %0d expected 55555555 1", bus.result, lat);
      end
      $display("b2b: xor -> %h lat %0d", bus.result, lat);
      @(negedge clk);
      run_op(3'd3, 32'h0F00_0000, 32'h0000_00F0, lat);
      checks++;
      if ({bus.result, lat == 1} !== {32'h0F00_00F0, 1'b1}) begin
         errors++;
         $display("FAIL back_to_back_or got res %h lat %0d expected 0F0000F0 1", bus.result, lat);
      end
      $display("b2b: or -> %h lat %0d", bus.result, lat);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_alu_random();
      test_mul();
      @(negedge clk);
      test_div();
      test_iter_random();
      test_ignore_start();
      test_reset_mid();
      test_reserved();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_core.md
CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have port S_AXI_ACLK  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port op_a  in  DATA_WIDTH  operand A, from slave register 0.
REQ-005 SHALL have port op_b  in  DATA_WIDTH  operand B, from slave register 1.
REQ-006 SHALL have port opcode  in  3  operation select, from slave register 2 bits [2:0].
REQ-007 SHALL have port start  in  1  one-cycle pulse on a write to slave register 2 bit 31.
REQ-008 SHALL have port result  out  DATA_WIDTH  registered result, read back via slave register 3.
REQ-009 SHALL have port busy  out  1  high while an operation is in progress.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port carry  out  1  sticky carry/borrow of the last ADD/SUB.
REQ-012 SHALL have port err  out  1  last operation was DIV by zero or reserved opcode.

Function
REQ-013 SHALL decode opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 DIV, 7 reserved.
REQ-014 SHALL implement FSM states IDLE, EXEC, DONE; IDLE->DONE for opcodes 0-4 and 7; IDLE->EXEC for 5-6; EXEC->DONE at iteration count 31; DONE->IDLE unconditionally.
REQ-015 SHALL sample start only in IDLE; when start is sampled at edge k, it SHALL latch op_a, op_b and opcode at edge k.
REQ-016 SHALL ignore start in EXEC or DONE, with no effect on latched operands or result.
REQ-017 SHALL, for opcodes 0-4, load result at edge k, with done high in the cycle after edge k (latency 1).
REQ-018 SHALL compute MUL as an unsigned shift-add over 32 iterations, one bit per cycle; result = low DATA_WIDTH bits of the product; overflow is discarded.
REQ-019 SHALL compute DIV as unsigned restoring division over 32 iterations; result = quotient.
REQ-020 SHALL, for MUL/DIV, load result at edge k+32, with done high in the cycle after edge k+32 (latency 33).
REQ-021 SHALL, for DIV with op_b = 0, still take 33 cycles, set result = all ones, and set err = 1.
REQ-022 SHALL, for opcode 7, set result = 0 and err = 1 with latency 1.
REQ-023 SHALL assert busy in EXEC and DONE and deassert it in IDLE; done SHALL be 1 only in DONE.
REQ-024 SHALL set carry to the carry-out for ADD and the borrow for SUB; other opcodes SHALL leave carry unchanged.
REQ-025 SHALL clear err when any new operation is accepted, then set it per REQ-021/022.
REQ-026 SHALL hold result stable from DONE until the next accepted operation completes.
REQ-027 SHALL accept start asserted in the first IDLE cycle after DONE, giving back-to-back operations with a one-cycle gap.

Reset
REQ-028 SHALL, on S_AXI_ARESETN low at any time (including mid-EXEC), immediately force state to IDLE, result to 0, busy, done, carry and err to 0, and the iteration counter to 0.
REQ-029 SHALL accept start no earlier than the first rising edge after reset release.

Structure
REQ-030 SHALL define the opcode enum, FSM state enum, DATA_WIDTH default and iteration count constant in shared package calc_pkg.
REQ-031 SHALL place the MUL/DIV iterative datapath in one sub-module, calc_iter, with the FSM and ALU kept in calc_core.
REQ-032 SHALL take its clock/reset from the AXI4-Lite slave; the slave maps register 3 read data to result and bits {err, carry, busy} into register 2 read bits [30:28].

Verification
REQ-033 SHALL test ADD: op_a = 0xFFFFFFFF, op_b = 1, start -> result 0, carry 1, done 1 cycle after start.
REQ-034 SHALL test MUL: op_a = 7, op_b = 6 -> result 42, busy for 33 cycles, single done pulse at cycle 33.
REQ-035 SHALL test DIV: op_a = 100, op_b = 7 -> result 14, err 0; then op_b = 0 -> result 0xFFFFFFFF, err 1 at cycle 33.
REQ-036 SHALL test start re-pulse and operand changes at cycle 10 of MUL 3x5 -> ignored, result 15.
REQ-037 SHALL test reset asserted at cycle 15 of DIV -> all outputs 0 immediately; after release, SUB 5-3 -> result 2, carry 0.
REQ-038 SHALL test opcode 7 -> result 0, err 1, latency 1; following AND 0xF0F0 & 0xFF00 -> result 0xF000, err 0.
